// File: rtl/apogeo_pkg.sv
//------------------------------------------------------------------------------
// apogeo_pkg : shared datapath types for the operand bypass network
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package apogeo_pkg;

  typedef logic [31:0] data_word_t;
  typedef logic [4:0]  regfile_address_t;

  typedef struct packed {
    data_word_t       data;
    regfile_address_t reg_dest;
  } bypass_entry_t;

  localparam regfile_address_t REG_X0 = 5'd0;

endpackage

`default_nettype wire

// File: rtl/result_match_cam.sv
//------------------------------------------------------------------------------
// result_match_cam : per-entry destination compare against one issuing source
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module result_match_cam
  import apogeo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][4:0] dests_i,
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PTR_W-1:0]      youngest_i,
  input  logic [4:0]            src_i,
  output logic                  any_match_o,
  output logic                  youngest_match_o
);

  logic [DEPTH-1:0] match;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
      assign match[i] = valid_i[i] && (dests_i[i] == src_i);
    end
  endgenerate

  assign any_match_o      = |match;
  assign youngest_match_o = match[youngest_i];

endmodule

`default_nettype wire

// File: rtl/bypass_result_buffer.sv
//------------------------------------------------------------------------------
// bypass_result_buffer : in-order result FIFO feeding the writeback register,
//                        with commit/writeback forwarding and stale-hazard flag
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bypass_result_buffer
  import apogeo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        result_valid_i,
  input  logic [31:0] result_i,
  input  logic [4:0]  result_reg_dest_i,
  output logic        buffer_full_o,
  output logic [31:0] commit_operand_o,
  output logic [4:0]  commit_reg_dest_o,
  output logic [31:0] writeback_operand_o,
  output logic [4:0]  writeback_reg_dest_o,
  output logic        regfile_write_o,
  input  logic [4:0]  reg_src_A_i,
  input  logic [4:0]  reg_src_B_i,
  output logic        stale_hazard_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  bypass_entry_t    mem_q [DEPTH];
  bypass_entry_t    mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wb_valid_q, wb_valid_d;
  bypass_entry_t    wb_q, wb_d;

  logic                  push, pop;
  logic [PTR_W-1:0]      youngest;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0][4:0] dests;
  bypass_entry_t         commit_entry;
  logic                  any_a, young_a, any_b, young_b;

  assign buffer_full_o = (count_q == FULL_COUNT);
  assign push = result_valid_i && !buffer_full_o && !flush_i && (result_reg_dest_i != REG_X0);
  // Popping is gated on registered count, so a push into an empty buffer waits a cycle.
  assign pop  = (count_q != '0) && !stall_i && !flush_i;
  assign youngest = tail_q - PTR_ONE;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
      logic [PTR_W-1:0] offset;
      assign offset         = PTR_W'(i) - head_q;
      assign entry_valid[i] = (CNT_W'(offset) < count_q);
      assign dests[i]       = mem_q[i].reg_dest;
    end
  endgenerate

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wb_valid_d = 1'b0;
    wb_d       = wb_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        wb_valid_d = 1'b1;
        wb_d       = mem_q[head_q];
        head_d     = head_q + PTR_ONE;
      end
      if (push) begin
        mem_d[tail_q] = '{data: result_i, reg_dest: result_reg_dest_i};
        tail_d        = tail_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mem_q      <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
    end
  end

  assign commit_entry         = (count_q != '0) ? mem_q[youngest] : '0;
  assign commit_operand_o     = commit_entry.data;
  assign commit_reg_dest_o    = commit_entry.reg_dest;
  assign writeback_operand_o  = wb_valid_q ? wb_q.data : '0;
  assign writeback_reg_dest_o = wb_valid_q ? wb_q.reg_dest : '0;
  assign regfile_write_o      = wb_valid_q;

  result_match_cam #(.DEPTH(DEPTH)) u_cam_a (
    .dests_i          (dests),
    .valid_i          (entry_valid),
    .youngest_i       (youngest),
    .src_i            (reg_src_A_i),
    .any_match_o      (any_a),
    .youngest_match_o (young_a)
  );

  result_match_cam #(.DEPTH(DEPTH)) u_cam_b (
    .dests_i          (dests),
    .valid_i          (entry_valid),
    .youngest_i       (youngest),
    .src_i            (reg_src_B_i),
    .any_match_o      (any_b),
    .youngest_match_o (young_b)
  );

  // An older match hidden behind a non-matching youngest entry cannot be forwarded.
  assign stale_hazard_o = ((reg_src_A_i != REG_X0) && any_a && !young_a) ||
                          ((reg_src_B_i != REG_X0) && any_b && !young_b);

endmodule

`default_nettype wire

// File: tb/tb_bypass_result_buffer.sv
//------------------------------------------------------------------------------
// tb_bypass_result_buffer : directed scoreboard bench for bypass_result_buffer
// Revision                : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bypass_result_buffer;
  import apogeo_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        stall_i;
  logic        result_valid_i;
  logic [31:0] result_i;
  logic [4:0]  result_reg_dest_i;
  logic        buffer_full_o;
  logic [31:0] commit_operand_o;
  logic [4:0]  commit_reg_dest_o;
  logic [31:0] writeback_operand_o;
  logic [4:0]  writeback_reg_dest_o;
  logic        regfile_write_o;
  logic [4:0]  reg_src_A_i;
  logic [4:0]  reg_src_B_i;
  logic        stale_hazard_o;

  always #5 clk_i = ~clk_i;

  bypass_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i                (clk_i),
    .rst_n_i              (rst_n_i),
    .flush_i              (flush_i),
    .stall_i              (stall_i),
    .result_valid_i       (result_valid_i),
    .result_i             (result_i),
    .result_reg_dest_i    (result_reg_dest_i),
    .buffer_full_o        (buffer_full_o),
    .commit_operand_o     (commit_operand_o),
    .commit_reg_dest_o    (commit_reg_dest_o),
    .writeback_operand_o  (writeback_operand_o),
    .writeback_reg_dest_o (writeback_reg_dest_o),
    .regfile_write_o      (regfile_write_o),
    .reg_src_A_i          (reg_src_A_i),
    .reg_src_B_i          (reg_src_B_i),
    .stale_hazard_o       (stale_hazard_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: expected FIFO contents and the expected writeback register.
  bypass_entry_t model_q[$];
  logic          wb_v_m;
  bypass_entry_t wb_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic haz_m(input logic [4:0] s);
    logic hit;
    hit = 1'b0;
    if (s == 5'd0 || model_q.size() == 0) return 1'b0;
    foreach (model_q[i]) if (model_q[i].reg_dest == s) hit = 1'b1;
    return hit && (model_q[model_q.size()-1].reg_dest != s);
  endfunction

  task automatic check_outputs(input string tag);
    bypass_entry_t c;
    c = (model_q.size() != 0) ? model_q[model_q.size()-1] : '0;
    chk({tag, ".full"},       32'(buffer_full_o),        32'(model_q.size() == DEPTH));
    chk({tag, ".commit_op"},  commit_operand_o,          c.data);
    chk({tag, ".commit_rd"},  32'(commit_reg_dest_o),    32'(c.reg_dest));
    chk({tag, ".rf_we"},      32'(regfile_write_o),      32'(wb_v_m));
    chk({tag, ".wb_op"},      writeback_operand_o,       wb_v_m ? wb_m.data : 32'd0);
    chk({tag, ".wb_rd"},      32'(writeback_reg_dest_o), wb_v_m ? 32'(wb_m.reg_dest) : 32'd0);
    chk({tag, ".hazard"},     32'(stale_hazard_o),
        32'(haz_m(reg_src_A_i) | haz_m(reg_src_B_i)));
  endtask

  task automatic step(input string tag, input logic v, input logic [4:0] d,
                      input logic [31:0] data, input logic st, input logic fl,
                      input logic [4:0] sa, input logic [4:0] sb);
    logic push_ok, pop_ok;
    result_valid_i    = v;
    result_reg_dest_i = d;
    result_i          = data;
    stall_i           = st;
    flush_i           = fl;
    reg_src_A_i       = sa;
    reg_src_B_i       = sb;
    #1;
    check_outputs(tag);
    push_ok = v && (model_q.size() < DEPTH) && !fl && (d != 5'd0);
    pop_ok  = (model_q.size() != 0) && !st && !fl;
    @(posedge clk_i);
    #1;
    if (fl) begin
      model_q.delete();
      wb_v_m = 1'b0;
    end else begin
      if (pop_ok) begin
        wb_m   = model_q.pop_front();
        wb_v_m = 1'b1;
      end else begin
        wb_v_m = 1'b0;
      end
      if (push_ok) model_q.push_back('{data: data, reg_dest: d});
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    model_q.delete();
    wb_v_m = 1'b0;
    wb_m   = '0;
  endtask

  initial begin
    rst_n_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; result_valid_i = 1'b0;
    result_i = '0; result_reg_dest_i = '0; reg_src_A_i = '0; reg_src_B_i = '0;
    wb_v_m = 1'b0; wb_m = '0;

    // 1: reset and idle
    do_reset();
    check_outputs("reset");
    step("idle0", 0, 0, 0, 0, 0, 0, 0);
    step("idle1", 0, 0, 0, 0, 0, 0, 0);

    // 2: single push, commit then writeback
    step("t2_push", 1, 5'd5, 32'hA5A5_0001, 0, 0, 0, 0);
    chk("t2_commit_rd", 32'(commit_reg_dest_o), 32'd5);
    chk("t2_commit_op", commit_operand_o, 32'hA5A5_0001);
    step("t2_pop", 0, 0, 0, 0, 0, 0, 0);
    chk("t2_wb_rd", 32'(writeback_reg_dest_o), 32'd5);
    chk("t2_wb_op", writeback_operand_o, 32'hA5A5_0001);
    chk("t2_rf_we", 32'(regfile_write_o), 32'd1);
    chk("t2_commit_empty", 32'(commit_reg_dest_o), 32'd0);
    step("t2_after", 0, 0, 0, 0, 0, 0, 0);
    chk("t2_rf_we_drop", 32'(regfile_write_o), 32'd0);

    // 3: fill under stall, refuse while full, drain in order
    for (int i = 1; i <= 4; i++)
      step("t3_fill", 1, 5'(i), 32'h1000_0000 + 32'(i), 1, 0, 0, 0);
    chk("t3_full", 32'(buffer_full_o), 32'd1);
    step("t3_refuse", 1, 5'd6, 32'hBAD0_0006, 1, 0, 0, 0);
    chk("t3_refuse_rd", 32'(commit_reg_dest_o), 32'd4);
    step("t3_full_pop_push", 1, 5'd7, 32'hBAD0_0007, 0, 0, 0, 0);
    chk("t3_first_wb", 32'(writeback_reg_dest_o), 32'd1);
    for (int i = 0; i < 5; i++) step("t3_drain", 0, 0, 0, 0, 0, 0, 0);

    // 4: stale hazard
    step("t4_p7", 1, 5'd7, 32'h7777_0007, 1, 0, 0, 0);
    step("t4_p9", 1, 5'd9, 32'h9999_0009, 1, 0, 0, 0);
    step("t4_a7", 0, 0, 0, 1, 0, 5'd7, 0);
    chk("t4_haz_a7", 32'(stale_hazard_o), 32'd1);
    step("t4_a9", 0, 0, 0, 1, 0, 5'd9, 0);
    chk("t4_haz_a9", 32'(stale_hazard_o), 32'd0);
    step("t4_a0", 0, 0, 0, 1, 0, 5'd0, 0);
    chk("t4_haz_a0", 32'(stale_hazard_o), 32'd0);
    step("t4_b7", 0, 0, 0, 1, 0, 5'd9, 5'd7);
    chk("t4_haz_b7", 32'(stale_hazard_o), 32'd1);
    for (int i = 0; i < 3; i++) step("t4_drain", 0, 0, 0, 0, 0, 5'd7, 0);

    // 5: x0 push dropped
    step("t5_x0", 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("t5_commit_rd", 32'(commit_reg_dest_o), 32'd0);
    chk("t5_commit_op", commit_operand_o, 32'd0);
    step("t5_idle", 0, 0, 0, 0, 0, 0, 0);

    // 6: flush beats concurrent push and pop
    for (int i = 0; i < 3; i++)
      step("t6_fill", 1, 5'(10 + i), 32'h6000_0000 + 32'(i), 1, 0, 0, 0);
    step("t6_flush", 1, 5'd20, 32'h6000_0020, 0, 1, 0, 0);
    chk("t6_commit_rd", 32'(commit_reg_dest_o), 32'd0);
    chk("t6_rf_we", 32'(regfile_write_o), 32'd0);
    chk("t6_full", 32'(buffer_full_o), 32'd0);
    step("t6_idle", 0, 0, 0, 0, 0, 0, 0);

    // pointer wrap: streaming push/pop, then fill/drain across the wrap
    for (int i = 0; i < 2 * DEPTH; i++)
      step("wrap_stream", 1, 5'(i + 1), 32'hC000_0000 + 32'(i), 0, 0, 5'(i), 5'(i + 1));
    for (int i = 0; i < 3; i++)
      step("wrap_fill", 1, 5'(21 + i), 32'hD000_0000 + 32'(i), 1, 0, 5'd21, 0);
    for (int i = 0; i < 2 * DEPTH; i++)
      step("wrap_mix", (i % 2) == 0, 5'(24 + i), 32'hE000_0000 + 32'(i), (i % 3) == 0, 0, 5'd22, 0);
    for (int i = 0; i < DEPTH + 1; i++) step("wrap_drain", 0, 0, 0, 0, 0, 0, 0);

    // reset asserted mid-operation
    step("mr_p1", 1, 5'd3, 32'h3333_0003, 1, 0, 0, 0);
    step("mr_p2", 1, 5'd4, 32'h4444_0004, 0, 0, 0, 0);
    do_reset();
    check_outputs("mid_reset");
    chk("mid_reset_rd", 32'(commit_reg_dest_o), 32'd0);
    step("mr_idle", 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
